pipeline_hazard_unit: RTL
=========================

// Module: pipeline_hazard_unit
// PURPOSE
//  Parametrised hazard unit for the 5-stage MIPS data path. It supplies ALU operand forwarding,
//  load-use and no-forward RAW stalls, and branch/jump squash of younger stages. Branches and
//  jumps are resolved in MEM. Sits beside the IF/ID, ID/EX and EX/MEM registers and drives their
//  write-enable, bubble and flush inputs plus the ALUA/ALUB forward muxes. Also keeps two
//  saturating performance counters.
// PARAMETERS
//  REG_AW     5   register index width
//  LOAD_LAT   1   stall cycles inserted on a load-use hazard (>=1)
//  ENABLE_FWD 1   1: forward from MEM/WB; 0: stall on any RAW until the writer is in WB
//  FLUSH_MASK 3'b111  bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM: stages squashed on M_PCSrc
//  CNT_W      16  perf counter width
// PORTS
//  Clk          in  1       clock, rising edge
//  Reset        in  1       synchronous, active-high
//  ID_Rs,ID_Rt  in  REG_AW  source registers of the instruction in ID
//  ID_Uses      in  2       [0] Rs read, [1] Rt read by the ID instruction
//  EX_Rs,EX_Rt  in  REG_AW  source registers of the instruction in EX
//  EX_RegWrite  in  1       EX instruction writes the register file
//  EX_MemRead   in  1       EX instruction is a load
//  EX_Rd        in  REG_AW  EX destination (post-RegDst mux)
//  M_RegWrite   in  1       MEM instruction writes the register file
//  M_MemRead    in  1       MEM instruction is a load
//  M_Rd         in  REG_AW  MEM destination
//  WB_RegWrite  in  1       WB write enable
//  WB_Rd        in  REG_AW  WB destination
//  M_PCSrc      in  1       taken branch/jr/jump resolved in MEM this cycle
//  PCWrite      out 1       PC load enable
//  IFID_Write   out 1       IF/ID load enable
//  IDEX_Bubble  out 1       load zeroed control words into ID/EX
//  Flush        out 3       squash per FLUSH_MASK bit order
//  FwdA,FwdB    out 2       00 register file, 01 M_ALUResult, 10 WB WriteData
//  ID_Bypass    out 2       [0]/[1]: ID Rs/Rt equals WB_Rd being written, so take WriteData
//  StallCycles  out CNT_W   count of cycles with IDEX_Bubble=1, saturating
//  FlushEvents  out CNT_W   count of cycles with M_PCSrc=1, saturating
// BEHAVIOUR
//  - Register 0 never matches: a destination of 0 never causes forwarding, bypass or a stall.
//  - Forwarding (ENABLE_FWD=1) is combinational.
//    - FwdA=01 if M_RegWrite & !M_MemRead & M_Rd==EX_Rs.
//    - Otherwise FwdA=10 if WB_RegWrite & WB_Rd==EX_Rs.
//    - Otherwise FwdA=00. MEM has priority over WB. FwdB is the same using EX_Rt.
//    - With ENABLE_FWD=0, FwdA and FwdB are always 00.
//  - Hazard detect (hz), combinational. hz=1 when ID_Uses selects a source that matches:
//    - ENABLE_FWD=1: the EX destination with EX_MemRead.
//    - ENABLE_FWD=0: the EX destination with EX_RegWrite, or the MEM destination with
//      M_RegWrite.
//  - FSM states are RUN and STALL. The down-counter cnt is $clog2(LOAD_LAT+1) bits wide.
//    - RUN: if hz & !M_PCSrc, then PCWrite=0, IFID_Write=0, IDEX_Bubble=1. Next state is STALL
//      with cnt=LOAD_LAT-1 if LOAD_LAT>1, else RUN.
//    - STALL: same three outputs while cnt>0. cnt decrements each cycle. Go to RUN after the
//      cycle with cnt==1.
//    - When ENABLE_FWD=0, the stall length comes from hz, not cnt: the FSM stays in RUN and
//      re-evaluates hz every cycle.
//  - M_PCSrc has priority over every stall.
//    - Same cycle: Flush=FLUSH_MASK, PCWrite=1, IFID_Write=1, IDEX_Bubble=0.
//    - Next state is RUN and cnt is cleared, so a pending load-use stall is abandoned.
//  - Flush is asserted in exactly the cycle M_PCSrc=1. There is no multi-cycle squash.
//  - Reset (any cycle, including mid-STALL): next state RUN, cnt=0, counters 0. While Reset=1,
//    outputs are PCWrite=1, IFID_Write=1, IDEX_Bubble=0, Flush=0, Fwd*=00, ID_Bypass=0.
//  - Counters increment on the clock edge and hold at 2^CNT_W-1.
// STRUCTURE
//  - hazard_pkg holds the FWD_RF/FWD_MEM/FWD_WB encodings, the RUN/STALL state enum and the
//    FLUSH_* bit indices.
//  - One sub-module, hazard_sat_counter (CNT_W, inc, Clk, Reset -> count), instantiated twice.
// TESTING
//  1. Back-to-back ALU RAW: add $3 in MEM and sub using $3 as Rs in EX.
//     -> FwdA=01, no stall.
//  2. Priority: add $3 in MEM and lw $3 in WB, Rs=3 in EX.
//     -> FwdA=01. Then M_MemRead=1 with WB match -> FwdA=10.
//  3. lw $5 in EX, beq using $5 in ID, LOAD_LAT=1.
//     -> one cycle PCWrite=0/IFID_Write=0/IDEX_Bubble=1, StallCycles=1. Run LOAD_LAT=3
//        -> 3 bubble cycles.
//  4. Load-use plus M_PCSrc=1 in the same cycle.
//     -> Flush=3'b111, no bubble. Next cycle RUN, StallCycles unchanged, FlushEvents=1.
//  5. ENABLE_FWD=0: add $7 in EX, use $7 in ID.
//     -> bubbles for 2 cycles until add reaches WB. ID_Bypass[0]=1 in the release cycle.
//  6. Reset asserted in STALL cycle 2 of 3, plus EX_Rd=0 with EX_MemRead.
//     -> next cycle RUN, counters 0. The Rd=0 load never stalls.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard unit.
//   FWD_*   : select codes for the ALUA/ALUB forward muxes
//   state_t : RUN / STALL states of the load-use stall sequencer
//   FLUSH_* : bit positions inside the Flush vector (IF/ID, ID/EX, EX/MEM)
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam int FLUSH_IFID  = 0;
  localparam int FLUSH_IDEX  = 1;
  localparam int FLUSH_EXMEM = 2;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter used for the hazard unit performance counters.
// Ports:
//   Clk   in  1      clock, rising edge
//   Reset in  1      synchronous, active-high, clears the count
//   inc   in  1      add one on this clock edge
//   count out CNT_W  current count, holds at all-ones
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard unit for the 5-stage MIPS data path: ALU operand forwarding,
// load-use / no-forward RAW stalls, squash of younger stages on a branch or
// jump resolved in MEM, plus two saturating performance counters.
// Ports:
//   Clk, Reset                 clock (rising edge), synchronous active-high reset
//   ID_Rs, ID_Rt, ID_Uses      sources of the ID instruction and which are read
//   EX_Rs, EX_Rt               sources of the EX instruction
//   EX_RegWrite, EX_MemRead,
//   EX_Rd                      EX destination and its write/load flags
//   M_RegWrite, M_MemRead, M_Rd  MEM destination and its write/load flags
//   WB_RegWrite, WB_Rd         register file write port
//   M_PCSrc                    taken branch/jump resolved in MEM
//   PCWrite, IFID_Write        load enables for PC and IF/ID
//   IDEX_Bubble                insert zeroed control into ID/EX
//   Flush                      per-stage squash (bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM)
//   FwdA, FwdB                 ALU operand forward selects
//   ID_Bypass                  ID sources take WB WriteData
//   StallCycles, FlushEvents   saturating performance counters
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int         REG_AW     = 5,
  parameter int         LOAD_LAT   = 1,
  parameter int         ENABLE_FWD = 1,
  parameter logic [2:0] FLUSH_MASK = 3'b111,
  parameter int         CNT_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic [1:0]        ID_Uses,
  input  logic [REG_AW-1:0] EX_Rs,
  input  logic [REG_AW-1:0] EX_Rt,
  input  logic              EX_RegWrite,
  input  logic              EX_MemRead,
  input  logic [REG_AW-1:0] EX_Rd,
  input  logic              M_RegWrite,
  input  logic              M_MemRead,
  input  logic [REG_AW-1:0] M_Rd,
  input  logic              WB_RegWrite,
  input  logic [REG_AW-1:0] WB_Rd,
  input  logic              M_PCSrc,
  output logic              PCWrite,
  output logic              IFID_Write,
  output logic              IDEX_Bubble,
  output logic [2:0]        Flush,
  output logic [1:0]        FwdA,
  output logic [1:0]        FwdB,
  output logic [1:0]        ID_Bypass,
  output logic [CNT_W-1:0]  StallCycles,
  output logic [CNT_W-1:0]  FlushEvents
);

  localparam int              CW       = $clog2(LOAD_LAT + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(LOAD_LAT - 1);

  // $0 is hard-wired, so a zero destination never produces a dependence.
  function automatic logic reg_match(input logic [REG_AW-1:0] dst,
                                     input logic [REG_AW-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

  logic [1:0] fwd_a_c, fwd_b_c;
  logic [1:0] bypass_c;
  logic       hz_fwd, hz_nofwd, hz;
  logic       stall;
  state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // MEM wins over WB because it holds the younger result; a load in MEM has
  // no data yet, so it falls through to WB.
  always_comb begin
    fwd_a_c = FWD_RF;
    fwd_b_c = FWD_RF;
    if (M_RegWrite && !M_MemRead && reg_match(M_Rd, EX_Rs)) begin
      fwd_a_c = FWD_MEM;
    end else if (WB_RegWrite && reg_match(WB_Rd, EX_Rs)) begin
      fwd_a_c = FWD_WB;
    end
    if (M_RegWrite && !M_MemRead && reg_match(M_Rd, EX_Rt)) begin
      fwd_b_c = FWD_MEM;
    end else if (WB_RegWrite && reg_match(WB_Rd, EX_Rt)) begin
      fwd_b_c = FWD_WB;
    end
  end

  assign bypass_c[0] = WB_RegWrite && reg_match(WB_Rd, ID_Rs);
  assign bypass_c[1] = WB_RegWrite && reg_match(WB_Rd, ID_Rt);

  // With forwarding only a load in EX is unresolvable; without it any pending
  // writer in EX or MEM blocks the reader until it reaches WB (ID_Bypass then
  // covers the WB case).
  assign hz_fwd =
      (ID_Uses[0] && EX_MemRead && reg_match(EX_Rd, ID_Rs)) ||
      (ID_Uses[1] && EX_MemRead && reg_match(EX_Rd, ID_Rt));

  assign hz_nofwd =
      (ID_Uses[0] && ((EX_RegWrite && reg_match(EX_Rd, ID_Rs)) ||
                      (M_RegWrite  && reg_match(M_Rd,  ID_Rs)))) ||
      (ID_Uses[1] && ((EX_RegWrite && reg_match(EX_Rd, ID_Rt)) ||
                      (M_RegWrite  && reg_match(M_Rd,  ID_Rt))));

  assign hz = (ENABLE_FWD != 0) ? hz_fwd : hz_nofwd;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The first stall cycle is issued from RUN; STALL covers the remaining
  // LOAD_LAT-1 cycles. A taken branch kills the stalled instruction anyway,
  // so it cancels any stall in progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (M_PCSrc) begin
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (hz) begin
            stall = 1'b1;
            if ((ENABLE_FWD != 0) && (LOAD_LAT > 1)) begin
              state_d = STALL;
              cnt_d   = CNT_LOAD;
            end
          end
        end
        STALL: begin
          if (cnt_q != '0) begin
            stall = 1'b1;
            cnt_d = cnt_q - CW'(1);
          end
          if (cnt_q <= CW'(1)) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Bubble = 1'b0;
    Flush       = '0;
    FwdA        = FWD_RF;
    FwdB        = FWD_RF;
    ID_Bypass   = '0;
    if (!Reset) begin
      PCWrite     = !stall;
      IFID_Write  = !stall;
      IDEX_Bubble = stall;
      if (M_PCSrc) begin
        Flush[FLUSH_IFID]  = FLUSH_MASK[FLUSH_IFID];
        Flush[FLUSH_IDEX]  = FLUSH_MASK[FLUSH_IDEX];
        Flush[FLUSH_EXMEM] = FLUSH_MASK[FLUSH_EXMEM];
      end
      if (ENABLE_FWD != 0) begin
        FwdA = fwd_a_c;
        FwdB = fwd_b_c;
      end
      ID_Bypass = bypass_c;
    end
  end

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (IDEX_Bubble),
    .count (StallCycles)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (M_PCSrc),
    .count (FlushEvents)
  );

endmodule
